// File: rtl/timer_counter_core.sv
// timer_counter_core: prescaled down-counter timer with one-shot and auto-reload
// modes. It produces a sticky expiry flag, a one-cycle expiry strobe and a live
// count readback. Single clock domain, asynchronous active-low reset.
module timer_counter_core #(
  parameter int WIDTH          = 32,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [WIDTH-1:0]          load_value,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      auto_reload,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      expired_clr,
  output logic [WIDTH-1:0]          count,
  output logic                      running,
  output logic                      expired,
  output logic                      expired_pulse
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t                    state;
  logic [PRESCALE_WIDTH-1:0] psc;
  logic                      start_q;
  logic                      start_evt;
  logic                      tick;
  logic                      load_zero;

  // The start input is a register level, so only its rising edge acts.
  assign start_evt = start & ~start_q;
  // Using >= means lowering prescale mid-run cannot strand psc above it.
  assign tick      = (psc >= prescale);
  assign load_zero = (load_value == '0);

  // Timer FSM with the counter, prescaler and all outputs registered together.
  // Later assignments win, so an expiry in the same cycle overrides expired_clr.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      count         <= '0;
      psc           <= '0;
      start_q       <= 1'b0;
      running       <= 1'b0;
      expired       <= 1'b0;
      expired_pulse <= 1'b0;
    end else begin
      start_q       <= start;
      expired_pulse <= 1'b0;
      if (expired_clr) begin
        expired <= 1'b0;
      end

      if (stop) begin
        // Halt: count freezes, any simultaneous start edge is discarded.
        state   <= IDLE;
        running <= 1'b0;
        psc     <= '0;
      end else if (start_evt) begin
        psc <= '0;
        if (!load_zero) begin
          count   <= load_value;
          state   <= RUNNING;
          running <= 1'b1;
        end else begin
          // A zero load expires once and parks, rather than re-firing every tick.
          count         <= '0;
          state         <= EXPIRED;
          running       <= 1'b0;
          expired       <= 1'b1;
          expired_pulse <= 1'b1;
        end
      end else if (state == RUNNING) begin
        if (tick) begin
          psc <= '0;
          if (count > WIDTH'(1)) begin
            count <= count - WIDTH'(1);
          end else begin
            expired       <= 1'b1;
            expired_pulse <= 1'b1;
            if (auto_reload && !load_zero) begin
              count <= load_value;
            end else begin
              count   <= '0;
              state   <= EXPIRED;
              running <= 1'b0;
            end
          end
        end else begin
          psc <= psc + PRESCALE_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_timer_counter_core.sv
// tb_timer_counter_core: directed scenarios followed by randomized stimulus,
// every cycle compared against a behavioural timer model.
module tb_timer_counter_core;

  localparam int W = 32;
  localparam int P = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [W-1:0]  load_value;
  logic          start;
  logic          stop;
  logic          auto_reload;
  logic [P-1:0]  prescale;
  logic          expired_clr;
  logic [W-1:0]  count;
  logic          running;
  logic          expired;
  logic          expired_pulse;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: a timer is either active or not; time passes in
  // prescaler phases, and each full period removes one unit from the count.
  longint m_count;
  int     m_phase;
  bit     m_active;
  bit     m_sticky;
  bit     m_pulse;
  bit     m_start_prev;

  timer_counter_core #(.WIDTH(W), .PRESCALE_WIDTH(P)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .load_value    (load_value),
    .start         (start),
    .stop          (stop),
    .auto_reload   (auto_reload),
    .prescale      (prescale),
    .expired_clr   (expired_clr),
    .count         (count),
    .running       (running),
    .expired       (expired),
    .expired_pulse (expired_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count      = 0;
    m_phase      = 0;
    m_active     = 0;
    m_sticky     = 0;
    m_pulse      = 0;
    m_start_prev = 0;
  endtask

  // One clock edge of the model, using the inputs held across that edge.
  task automatic model_step();
    bit fire;
    bit evt;
    fire = 0;
    evt  = start && !m_start_prev;
    m_start_prev = start;
    if (stop) begin
      m_active = 0;
      m_phase  = 0;
    end else if (evt) begin
      m_phase = 0;
      if (load_value != 0) begin
        m_count  = load_value;
        m_active = 1;
      end else begin
        m_count  = 0;
        m_active = 0;
        fire     = 1;
      end
    end else if (m_active) begin
      if (m_phase >= int'(prescale)) begin
        m_phase = 0;
        if (m_count > 1) begin
          m_count = m_count - 1;
        end else begin
          fire = 1;
          if (auto_reload && load_value != 0) begin
            m_count = load_value;
          end else begin
            m_count  = 0;
            m_active = 0;
          end
        end
      end else begin
        m_phase = m_phase + 1;
      end
    end
    m_pulse = fire;
    if (fire) m_sticky = 1;
    else if (expired_clr) m_sticky = 0;
  endtask

  task automatic check_all();
    chk("count", count, W'(m_count));
    chk("running", W'(running), W'(m_active));
    chk("expired", W'(expired), W'(m_sticky));
    chk("expired_pulse", W'(expired_pulse), W'(m_pulse));
  endtask

  // Advance one clock: model follows the edge, outputs checked on the falling edge.
  task automatic cycle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    load_value  = '0;
    start       = 1'b0;
    stop        = 1'b0;
    auto_reload = 1'b0;
    prescale    = '0;
    expired_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    reset_n = 1'b1;

    // One-shot, prescale 0, load 5.
    load_value = 5; start = 1'b1;
    cycle(8);
    start = 1'b0;
    cycle(1);

    // Auto-reload, load 3, prescale 1, then a lone expired_clr.
    load_value = 3; prescale = 1; auto_reload = 1'b1; start = 1'b1;
    cycle(20);
    expired_clr = 1'b1;
    cycle(1);
    expired_clr = 1'b0;
    cycle(8);
    stop = 1'b1;
    cycle(1);
    stop = 1'b0; start = 1'b0; auto_reload = 1'b0; prescale = 0;
    cycle(1);

    // Stop at count 4, then a fresh start edge runs to expiry.
    load_value = 10; start = 1'b1;
    cycle(7);
    stop = 1'b1;
    cycle(2);
    stop = 1'b0; start = 1'b0;
    cycle(1);
    start = 1'b1;
    cycle(13);

    // Start edge under stop is dropped; held level gives no new event.
    start = 1'b0;
    cycle(1);
    start = 1'b1; stop = 1'b1;
    cycle(1);
    stop = 1'b0;
    cycle(3);

    // Zero load: immediate single expiry, never running.
    start = 1'b0; load_value = 0;
    cycle(1);
    start = 1'b1;
    cycle(3);
    start = 1'b0;
    cycle(1);

    // expired_clr held through the expiry edge: expiry wins, then clears.
    load_value = 2; expired_clr = 1'b1; start = 1'b1;
    cycle(4);
    expired_clr = 1'b0; start = 1'b0;
    cycle(1);

    // Restart mid-run with a new load value.
    load_value = 5; prescale = 3; start = 1'b1;
    cycle(13);
    start = 1'b0; load_value = 7;
    cycle(1);
    start = 1'b1;
    cycle(6);

    // Asynchronous reset mid-run: outputs clear without a clock edge.
    start = 1'b0; load_value = 20; prescale = 0;
    cycle(1);
    start = 1'b1;
    cycle(3);
    @(posedge clk);
    model_step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_count", count, '0);
    chk("async_running", W'(running), '0);
    chk("async_expired", W'(expired), '0);
    chk("async_pulse", W'(expired_pulse), '0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    start = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) start = ~start;
      stop        = ($urandom_range(0, 39) == 0);
      expired_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 9) == 0) begin
        load_value = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom_range(1, 12));
      end
      if ($urandom_range(0, 29) == 0) prescale = P'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) auto_reload = $urandom_range(0, 1);
      cycle(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
